// File: rtl/sub_diff_accum_if.sv
// Handshake bundle between the subtractor, the window accumulator and the next stage.
// master drives samples in and takes summaries out; slave is the accumulator.
interface sub_diff_accum_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_diff;
  logic              in_overflow;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_ovf_cnt;
  logic              out_acc_ovf;

  modport master (
    output in_valid, in_diff, in_overflow, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf_cnt, out_acc_ovf
  );

  modport slave (
    input  in_valid, in_diff, in_overflow, out_ready,
    output in_ready, out_valid, out_acc, out_ovf_cnt, out_acc_ovf
  );
endinterface

// File: rtl/sub_diff_accum.sv
// Sums WIN_LEN signed subtractor differences per window and counts flagged overflows.
// Define SUB_ACC_SAT_EN to clamp the accumulator on range errors instead of wrapping.
module sub_diff_accum #(
  parameter int DATA_W  = 4,
  parameter int ACC_W   = 8,
  parameter int WIN_LEN = 4,
  parameter int CNT_W   = 4
) (
  input logic             clk,
  input logic             rst,
  sub_diff_accum_if.slave bus
);
  localparam int SW = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic              acc_ovf_q;
  logic              in_ready_q, out_valid_q;
  logic [ACC_W:0]    sum;
  logic              rng_err;
  logic              accept, xfer;

  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = out_valid_q & bus.out_ready;

  // One guard bit above ACC_W: range error when it disagrees with the sign bit.
  always_comb begin
    sum     = {{(ACC_W+1-DATA_W){bus.in_diff[DATA_W-1]}}, bus.in_diff}
            + {acc_q[ACC_W-1], acc_q};
    rng_err = sum[ACC_W] ^ sum[ACC_W-1];
    acc_d   = sum[ACC_W-1:0];
`ifdef SUB_ACC_SAT_EN
    if (rng_err)
      acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    ovf_cnt_d = ovf_cnt_q;
    if (bus.in_overflow && (ovf_cnt_q != {CNT_W{1'b1}}))
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    cnt_d = cnt_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_cnt_q   <= '0;
      acc_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
            acc_ovf_q <= acc_ovf_q | rng_err;
            if (cnt_d == SW'(WIN_LEN)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (xfer) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_cnt_q   <= '0;
            acc_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_acc     = acc_q;
  assign bus.out_ovf_cnt = ovf_cnt_q;
  assign bus.out_acc_ovf = acc_ovf_q;
endmodule

// File: tb/tb_sub_diff_accum.sv
// Scoreboard bench for sub_diff_accum: default instance plus an ACC_W=5 instance.
module tb_sub_diff_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_diff_accum_if #(.DATA_W(4), .ACC_W(8), .CNT_W(4)) bus  ();
  sub_diff_accum_if #(.DATA_W(4), .ACC_W(5), .CNT_W(4)) bus5 ();

  sub_diff_accum #(.DATA_W(4), .ACC_W(8), .WIN_LEN(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus));
  sub_diff_accum #(.DATA_W(4), .ACC_W(5), .WIN_LEN(4), .CNT_W(4)) u_dut5 (
    .clk(clk), .rst(rst), .bus(bus5));

  typedef struct packed {
    logic [7:0] acc;
    logic [3:0] oc;
    logic       ao;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp5_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  // Reference: integer running sum, range-checked against a w-bit signed window.
  function automatic exp_t model(input logic [3:0][3:0] d, input logic [3:0] o, input int w);
    int   s, mx, mn;
    exp_t e;
    s = 0; e = '0;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    for (int i = 3; i >= 0; i--) begin
      s = s + int'($signed(d[i]));
      if (s > mx || s < mn) begin
        e.ao = 1'b1;
`ifdef SUB_ACC_SAT_EN
        s = (s > mx) ? mx : mn;
`else
        s = (s > mx) ? s - (1 << w) : s + (1 << w);
`endif
      end
      if (o[i] && e.oc != 4'hF) e.oc = e.oc + 4'd1;
    end
    e.acc = 8'(s);
    return e;
  endfunction

  task automatic send(input bit sel, input logic [3:0] d, input logic o);
    int g = 0;
    if (!sel) begin bus.in_valid = 1'b1; bus.in_diff = d; bus.in_overflow = o; end
    else begin bus5.in_valid = 1'b1; bus5.in_diff = d; bus5.in_overflow = o; end
    while (!(sel ? bus5.in_ready : bus.in_ready) && g < 50) begin
      @(posedge clk); #1; g++;
    end
    tot_cnt++;
    if (g >= 50) $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles, need 1", g);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus5.in_valid = 1'b0;
  endtask

  task automatic feed(input bit sel, input logic [3:0][3:0] d, input logic [3:0] o);
    if (!sel) exp_q.push_back(model(d, o, 8));
    else      exp5_q.push_back(model(d, o, 5));
    for (int i = 3; i >= 0; i--) send(sel, d[i], o[i]);
    // Summary must be visible right after the last accepting edge.
    tot_cnt++;
    if ((sel ? bus5.out_valid : bus.out_valid) !== 1'b1)
      $display("FAIL latency: out_valid=%0b after last accept, need 1", sel ? bus5.out_valid : bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic collect(input bit sel);
    exp_t e;
    int   g = 0;
    if (!sel) begin
      if (exp_q.size() == 0) begin $display("FAIL scoreboard: main queue empty"); tot_cnt++; return; end
      e = exp_q.pop_front();
    end else begin
      if (exp5_q.size() == 0) begin $display("FAIL scoreboard: w5 queue empty"); tot_cnt++; return; end
      e = exp5_q.pop_front();
    end
    while (!(sel ? bus5.out_valid : bus.out_valid) && g < 20) begin @(posedge clk); #1; g++; end
    tot_cnt++;
    if (g >= 20) $display("FAIL out_timeout: no out_valid in %0d cycles", g); else pass_cnt++;
    if (!sel) begin
      tot_cnt++;
      if (bus.out_acc !== e.acc) $display("FAIL out_acc: got %0h need %0h", bus.out_acc, e.acc);
      else pass_cnt++;
      tot_cnt++;
      if (bus.out_ovf_cnt !== e.oc) $display("FAIL out_ovf_cnt: got %0h need %0h", bus.out_ovf_cnt, e.oc);
      else pass_cnt++;
      tot_cnt++;
      if (bus.out_acc_ovf !== e.ao) $display("FAIL out_acc_ovf: got %0b need %0b", bus.out_acc_ovf, e.ao);
      else pass_cnt++;
      bus.out_ready = 1'b1;
    end else begin
      tot_cnt++;
      if (bus5.out_acc !== e.acc[4:0]) $display("FAIL w5_out_acc: got %0h need %0h", bus5.out_acc, e.acc[4:0]);
      else pass_cnt++;
      tot_cnt++;
      if (bus5.out_acc_ovf !== e.ao) $display("FAIL w5_out_acc_ovf: got %0b need %0b", bus5.out_acc_ovf, e.ao);
      else pass_cnt++;
      bus5.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus5.out_ready = 1'b0;
    tot_cnt++;
    if ((sel ? bus5.out_valid : bus.out_valid) !== 1'b0 || (sel ? bus5.in_ready : bus.in_ready) !== 1'b1)
      $display("FAIL post_xfer: out_valid=%0b in_ready=%0b need 0/1",
               sel ? bus5.out_valid : bus.out_valid, sel ? bus5.in_ready : bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tot_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b need 0", bus.out_valid); else pass_cnt++;
    tot_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b need 1", bus.in_ready); else pass_cnt++;
    tot_cnt++;
    if (bus.out_acc !== 8'h00) $display("FAIL rst_out_acc: got %0h need 0", bus.out_acc); else pass_cnt++;
    tot_cnt++;
    if (bus.out_ovf_cnt !== 4'h0 || bus.out_acc_ovf !== 1'b0)
      $display("FAIL rst_ovf: cnt=%0h acc_ovf=%0b need 0/0", bus.out_ovf_cnt, bus.out_acc_ovf);
    else pass_cnt++;
  endtask

  task automatic test_defaults();
    feed(0, {4'h1, 4'h2, 4'h3, 4'hF}, 4'b0000);
    collect(0);
    feed(0, {4'h7, 4'h8, 4'h1, 4'h0}, 4'b1010);
    collect(0);
  endtask

  task automatic test_acc_w5();
    feed(1, {4'h7, 4'h7, 4'h7, 4'h7}, 4'b0000);
    collect(1);
    feed(1, {4'h8, 4'h8, 4'h8, 4'h8}, 4'b0000);
    collect(1);
  endtask

  task automatic test_back_to_back();
    feed(0, {4'h7, 4'h7, 4'h7, 4'h7}, 4'b1111);
    collect(0);
    feed(0, {4'h8, 4'h8, 4'h8, 4'h8}, 4'b0110);
    collect(0);
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    feed(0, {4'h2, 4'h3, 4'hF, 4'h4}, 4'b0100);
    held = exp_q[0].acc;
    bus.in_diff = 4'h7; bus.in_overflow = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = ~bus.in_valid;
      @(posedge clk); #1;
      tot_cnt++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_acc !== held)
        $display("FAIL bp_hold: in_ready=%0b out_valid=%0b acc=%0h need 0/1/%0h",
                 bus.in_ready, bus.out_valid, bus.out_acc, held);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    collect(0);
    feed(0, {4'h5, 4'h0, 4'h0, 4'h0}, 4'b0000);
    collect(0);
  endtask

  task automatic test_reset_mid();
    send(0, 4'h7, 1'b1);
    send(0, 4'h7, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tot_cnt++;
    if (bus.out_acc !== 8'h00 || bus.out_ovf_cnt !== 4'h0 || bus.in_ready !== 1'b1)
      $display("FAIL mid_rst: acc=%0h cnt=%0h in_ready=%0b need 0/0/1",
               bus.out_acc, bus.out_ovf_cnt, bus.in_ready);
    else pass_cnt++;
    feed(0, {4'h1, 4'h1, 4'h1, 4'h1}, 4'b0000);
    collect(0);
    // Reset while a summary is waiting drops it.
    feed(0, {4'h3, 4'h3, 4'h3, 4'h3}, 4'b1000);
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tot_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_acc !== 8'h00)
      $display("FAIL done_rst: out_valid=%0b in_ready=%0b acc=%0h need 0/1/0",
               bus.out_valid, bus.in_ready, bus.out_acc);
    else pass_cnt++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_diff = '0; bus.in_overflow = 1'b0; bus.out_ready = 1'b0;
    bus5.in_valid = 1'b0; bus5.in_diff = '0; bus5.in_overflow = 1'b0; bus5.out_ready = 1'b0;
    test_reset();
    test_defaults();
    test_acc_w5();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
